// File: rtl/qsize_buffer_reader.sv
// qsize_buffer_reader
//   Streams a burst of words out of the QSIZE buffer RAM. A burst is a run of
//   `count` consecutive addresses starting at `base_addr`, wrapping from
//   DEPTH-1 back to 0. Reads are issued to a RAM with a fixed READ_LATENCY.
//   Returned words land in a small skid FIFO, which feeds a valid/ready output
//   stream. Issue is credit-limited so that every outstanding read has a free
//   FIFO slot waiting for it. Downstream backpressure therefore throttles RAM
//   reads and never loses data.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   start         one-cycle burst request (ignored while busy)
//   base_addr     first buffer address of the burst
//   count         burst length in words, 0..DEPTH
//   abort         cancel the burst, flush everything, no done pulse
//   mem_raddr     registered RAM read address
//   mem_rdata     RAM read data, READ_LATENCY cycles after mem_raddr
//   out_valid     out_data holds a word
//   out_ready     downstream accepts the word
//   out_data      streamed word (0 when out_valid is low)
//   out_last      out_data is the final word of the burst
//   busy          burst in progress
//   done          one-cycle pulse after the final word is accepted
module qsize_buffer_reader #(
  parameter int DEPTH        = 512,
  parameter int READ_LATENCY = 2,
  parameter int WIDTH        = 16,
  parameter int FIFO_DEPTH   = READ_LATENCY + 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [CW-1:0]    count,
  input  logic             abort,
  output logic [AW-1:0]    mem_raddr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = OW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // (base + ofs) mod DEPTH. The offset never exceeds DEPTH-1, so a single
  // conditional subtraction covers non-power-of-two depths too.
  function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] base,
                                              input logic [CW-1:0] ofs);
    logic [CW:0] sum;
    sum = {2'b00, base} + {1'b0, ofs};
    if (sum >= (CW+1)'(DEPTH)) sum = sum - (CW+1)'(DEPTH);
    return sum[AW-1:0];
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  state_t                  state;
  logic [AW-1:0]           base_q;
  logic [CW-1:0]           cnt_q;
  logic [CW-1:0]           issued_q;
  logic [CW-1:0]           popped_q;
  logic                    vld_p0;
  logic [READ_LATENCY-1:0] vld_p1;
  logic [OW-1:0]           inflight_q;
  logic [OW-1:0]           occ_q;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [WIDTH-1:0]        fifo_mem [FIFO_DEPTH];

  logic                    push;
  logic                    pop;
  logic                    start_go;
  logic                    issue;
  logic                    any_issue;
  logic [SW-1:0]           credit;

  assign push      = vld_p1[READ_LATENCY-1];
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
  assign out_last  = out_valid && (popped_q == cnt_q - CW'(1));
  assign busy      = (state != IDLE);

  // The first read goes out on the same edge that accepts start. This keeps
  // first-word latency at READ_LATENCY+1 cycles.
  assign start_go  = (state == IDLE) && start && !abort && (count != '0);

  // Words in flight plus words held in the FIFO must never exceed FIFO_DEPTH.
  // A word leaving the FIFO this cycle frees its slot at the same edge, so it
  // is credited back immediately. This keeps one issue per cycle when
  // out_ready stays high.
  assign credit    = SW'(inflight_q) + SW'(occ_q) - SW'(pop);
  assign issue     = (state == ISSUE) && !abort && (credit < SW'(FIFO_DEPTH));
  assign any_issue = start_go || issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      mem_raddr  <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= '0;
      inflight_q <= '0;
      occ_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      done       <= 1'b0;
    end else if (abort) begin
      // Clearing the valid tags discards any read still in the RAM pipeline.
      state      <= IDLE;
      issued_q   <= '0;
      popped_q   <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= '0;
      inflight_q <= '0;
      occ_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;

      // p0 -> p1: the tag follows the registered address through the RAM latency.
      vld_p0     <= any_issue;
      vld_p1     <= (vld_p1 << 1) | READ_LATENCY'(vld_p0);
      inflight_q <= inflight_q + OW'(any_issue) - OW'(push);

      // p1 exit -> FIFO: the tag leaving the shift register meets its rdata.
      occ_q <= occ_q + OW'(push) - OW'(pop);
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);

      case (state)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              base_q    <= base_addr;
              cnt_q     <= count;
              issued_q  <= CW'(1);
              popped_q  <= '0;
              mem_raddr <= base_addr;
              state     <= (count == CW'(1)) ? DRAIN : ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            mem_raddr <= wrap_addr(base_q, issued_q);
            issued_q  <= issued_q + CW'(1);
            if (issued_q + CW'(1) == cnt_q) state <= DRAIN;
          end
        end
        DRAIN: begin
        end
        default: state <= IDLE;
      endcase

      // The final word can only leave after the last issue, i.e. in DRAIN.
      if (pop) begin
        popped_q <= popped_q + CW'(1);
        if (out_last) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

  // FIFO storage is data only; validity is tracked by occ_q.
  always_ff @(posedge clk) begin
    if (push && !abort) fifo_mem[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_qsize_buffer_reader.sv
module tb_qsize_buffer_reader;
  localparam int DEPTH = 512;
  localparam int RL    = 2;
  localparam int WIDTH = 16;
  localparam int FD    = RL + 2;
  localparam int AW    = 9;
  localparam int CW    = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW-1:0]    base_addr;
  logic [CW-1:0]    count;
  logic             abort;
  logic [AW-1:0]    mem_raddr;
  logic [WIDTH-1:0] mem_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             done;

  qsize_buffer_reader #(
    .DEPTH(DEPTH), .READ_LATENCY(RL), .WIDTH(WIDTH), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .abort(abort), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM model: RAM[i] = i, data valid RL cycles after the address.
  logic [AW-1:0] rd_pipe [RL];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_raddr;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = WIDTH'(rd_pipe[RL-1]);

  // Monitor: only this process writes the logs below.
  logic [WIDTH-1:0] got_q [$];
  bit               last_q [$];
  int               gcyc_q [$];
  int               raddr_q [$];
  int               cyc = 0;
  int               done_cnt = 0;
  int               done_cyc = 0;
  int               hold_bad = 0;
  int               hold_n = 0;
  logic [AW-1:0]    prev_raddr = '0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic             prev_last = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        hold_n++;
        if (!out_valid || out_data !== prev_data || out_last !== prev_last) hold_bad++;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
        gcyc_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready && !abort;
      prev_data  = out_data;
      prev_last  = out_last;
    end
    if (mem_raddr !== prev_raddr) begin
      raddr_q.push_back(int'(mem_raddr));
      prev_raddr = mem_raddr;
    end
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_start(input int b, input int c);
    @(posedge clk); #1;
    base_addr = AW'(b);
    count     = CW'(c);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int maxc, input string tag);
    int k;
    k = 0;
    while (done_cnt < target && k < maxc) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, done_cnt >= target, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g0, d0, r0, g1, bad, nlast;
    int exp042 [4] = '{510, 511, 0, 1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_last",  out_last, 0);
    check("rst_data",  out_data, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_raddr", mem_raddr, 0);
    rst = 1'b0;

    // Basic burst: 10..13, latency, last flag and done timing.
    g0 = got_q.size(); d0 = done_cnt;
    drive_start(10, 4);
    for (int i = 0; i <= RL; i++) begin
      @(negedge clk);
      check("lat_pre", out_valid, 0);
    end
    @(negedge clk);
    check("lat_first", out_valid, 1);
    check("lat_first_data", out_data, 10);
    wait_done(d0 + 1, 50, "t041_done_timeout");
    check("t041_len", got_q.size() - g0, 4);
    for (int i = 0; i < 4; i++) begin
      check("t041_data", got_q[g0+i], 10 + i);
      check("t041_last", last_q[g0+i], (i == 3) ? 1 : 0);
    end
    for (int i = 1; i < 4; i++) check("t041_consec", gcyc_q[g0+i] - gcyc_q[g0+i-1], 1);
    check("t041_done_cyc", done_cyc, gcyc_q[g0+3] + 1);
    repeat (3) @(negedge clk);
    check("t041_one_done", done_cnt, d0 + 1);

    // Address wrap at the top of the buffer.
    g0 = got_q.size(); d0 = done_cnt; r0 = raddr_q.size();
    drive_start(510, 4);
    wait_done(d0 + 1, 50, "t042_done_timeout");
    check("t042_nraddr", raddr_q.size() - r0, 4);
    check("t042_len", got_q.size() - g0, 4);
    for (int i = 0; i < 4; i++) begin
      check("t042_raddr", raddr_q[r0+i], exp042[i]);
      check("t042_data", got_q[g0+i], exp042[i]);
    end

    // Downstream stall: issues limited to FD, then everything delivered.
    out_ready = 1'b0;
    g0 = got_q.size(); d0 = done_cnt; r0 = raddr_q.size();
    drive_start(100, 8);
    repeat (20) @(negedge clk);
    #1;
    check("t043_issues", raddr_q.size() - r0, FD);
    check("t043_raddr", mem_raddr, 100 + FD - 1);
    check("t043_nowords", got_q.size() - g0, 0);
    check("t043_valid", out_valid, 1);
    check("t043_head", out_data, 100);
    check("t043_busy", busy, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(d0 + 1, 60, "t043_done_timeout");
    check("t043_len", got_q.size() - g0, 8);
    for (int i = 0; i < 8; i++) begin
      check("t043_data", got_q[g0+i], 100 + i);
      check("t043_last", last_q[g0+i], (i == 7) ? 1 : 0);
    end

    // Full-depth burst with random backpressure, wrapping inside the burst.
    g0 = got_q.size(); d0 = done_cnt;
    drive_start(300, DEPTH);
    for (int k = 0; k < 6000 && done_cnt < d0 + 1; k++) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
    end
    check("t044_done_timeout", done_cnt >= d0 + 1, 1);
    out_ready = 1'b1;
    check("t044_len", got_q.size() - g0, DEPTH);
    bad = 0; nlast = 0;
    for (int i = 0; i < DEPTH && g0 + i < got_q.size(); i++) begin
      if (got_q[g0+i] !== WIDTH'((300 + i) % DEPTH)) bad++;
      if (last_q[g0+i]) nlast++;
    end
    check("t044_bad_words", bad, 0);
    check("t044_nlast", nlast, 1);
    check("t044_last_pos", last_q[got_q.size()-1], 1);

    // Abort mid-burst, then a fresh two-word burst.
    g0 = got_q.size(); d0 = done_cnt;
    drive_start(200, 10);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    g1 = got_q.size();
    @(negedge clk);
    check("t045_flush_valid", out_valid, 0);
    check("t045_idle", busy, 0);
    check("t045_no_done", done_cnt, d0);
    drive_start(50, 2);
    wait_done(d0 + 1, 50, "t045_done_timeout");
    repeat (6) @(negedge clk);
    check("t045_len", got_q.size() - g1, 2);
    check("t045_w0", got_q[g1], 50);
    check("t045_w1", got_q[g1+1], 51);
    check("t045_w1_last", last_q[g1+1], 1);
    check("t045_one_done", done_cnt, d0 + 1);

    // Abort wins over start in the same cycle.
    g0 = got_q.size(); d0 = done_cnt;
    @(posedge clk); #1;
    base_addr = AW'(5); count = CW'(3); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_start_busy", busy, 0);
    repeat (8) @(negedge clk);
    check("abort_start_words", got_q.size() - g0, 0);
    check("abort_start_done", done_cnt, d0);

    // Zero-length burst.
    d0 = done_cnt; r0 = raddr_q.size();
    drive_start(77, 0);
    @(negedge clk);
    check("t046_done", done, 1);
    check("t046_busy", busy, 0);
    @(negedge clk);
    check("t046_done_pulse", done, 0);
    check("t046_no_raddr", raddr_q.size() - r0, 0);

    // Reset mid-burst.
    d0 = done_cnt;
    drive_start(400, 20);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_data",  out_data, 0);
    check("mrst_last",  out_last, 0);
    check("mrst_busy",  busy, 0);
    check("mrst_done",  done, 0);
    check("mrst_raddr", mem_raddr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mrst_no_done", done_cnt, d0);

    // First start after reset release is accepted on the next edge.
    g0 = got_q.size();
    base_addr = AW'(7); count = CW'(1); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 1);
    wait_done(d0 + 1, 30, "post_rst_done_timeout");
    check("post_rst_len", got_q.size() - g0, 1);
    check("post_rst_word", got_q[g0], 7);
    check("post_rst_last", last_q[g0], 1);

    check("hold_bad", hold_bad, 0);
    check("hold_seen", hold_n > 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
